// File: rtl/sk9822_rx.sv
// ============================================================================
// Module   : sk9822_rx
// Brief    : SK9822 clock/data stream receiver; frames start/LED/end words and
//            emits one pixel write per LED. Optional status counters enabled
//            by defining SK9822_RX_STATUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sk9822_rx #(
    parameter int NLEDS   = 16,
    parameter int TIMEOUT = 1024,
    localparam int AW     = $clog2(NLEDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          led_ck,
    input  logic          led_data,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic          frame_done,
    output logic [AW:0]   npix,
    output logic          overflow,
    output logic [15:0]   frame_count,
    output logic [7:0]    error_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;

    logic          r_ck_s1, r_ck_s2, r_ck_s3, r_d_s1, r_d_s2;
    logic [30:0]   r_sr;
    logic [4:0]    r_bc;
    logic [5:0]    r_zr;
    logic [AW:0]   r_idx;
    logic [TW-1:0] r_idle;

    logic          w_edge, w_bit, w_start, w_dec, w_timeout;
    logic          w_is_end, w_is_zero, w_is_pix, w_is_err;
    logic          w_idx_nz, w_full, w_fd, w_err;
    logic [31:0]   w_word;

    assign w_edge    = r_ck_s2 & ~r_ck_s3;
    assign w_bit     = r_d_s2;
    assign w_word    = {r_sr, w_bit};
    assign w_is_end  = (w_word == 32'hFFFF_FFFF);
    assign w_is_zero = (w_word == 32'h0000_0000);
    assign w_is_pix  = (w_word[31:29] == 3'b111) && !w_is_end;
    assign w_is_err  = !(w_is_pix || w_is_end || w_is_zero);
    assign w_idx_nz  = (r_idx != '0);
    assign w_full    = (r_idx == (AW+1)'(NLEDS));
    // A zero word mid-frame closes the current frame only if it held pixels.
    assign w_fd      = (w_dec && (w_is_end || (w_is_zero && w_idx_nz))) ||
                       (w_timeout && w_idx_nz);
    assign w_err     = w_dec && w_is_err;

    always_ff @(posedge clk) begin
        if (reset) r_state <= HUNT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_dec       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_edge && !w_bit && (r_zr == 6'd31)) begin
                    w_start     = 1'b1;
                    w_state_nxt = FRAME;
                end
            end
            FRAME: begin
                if (w_edge) begin
                    if (r_bc == 5'd31) begin
                        w_dec = 1'b1;
                        if (w_is_end || w_is_err) w_state_nxt = HUNT;
                    end
                end else if (r_idle == TW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = HUNT;
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ck_s1 <= 1'b0; r_ck_s2 <= 1'b0; r_ck_s3 <= 1'b0;
            r_d_s1  <= 1'b0; r_d_s2  <= 1'b0;
            r_sr    <= '0;   r_bc    <= '0;   r_zr    <= '0;
            r_idx   <= '0;   r_idle  <= '0;
            we      <= 1'b0; waddr   <= '0;   wdata   <= '0;
            frame_done <= 1'b0; npix <= '0;   overflow <= 1'b0;
        end else begin
            r_ck_s1    <= led_ck;
            r_ck_s2    <= r_ck_s1;
            r_ck_s3    <= r_ck_s2;
            r_d_s1     <= led_data;
            r_d_s2     <= r_d_s1;
            we         <= 1'b0;
            frame_done <= 1'b0;

            if (w_edge) r_sr <= w_word[30:0];

            if (r_state == FRAME) begin
                r_zr <= '0;
                if (w_edge) begin
                    r_bc   <= r_bc + 5'd1;
                    r_idle <= '0;
                end else begin
                    r_idle <= r_idle + TW'(1);
                end
            end else begin
                r_bc   <= '0;
                r_idle <= '0;
                if (w_start)     r_zr <= '0;
                else if (w_edge) r_zr <= w_bit ? 6'd0 : r_zr + 6'd1;
            end

            if (w_start) begin
                r_idx    <= '0;
                overflow <= 1'b0;
            end

            if (w_dec && w_is_pix) begin
                if (!w_full) begin
                    we    <= 1'b1;
                    waddr <= r_idx[AW-1:0];
                    wdata <= {3'b000, w_word[28:0]};
                    r_idx <= r_idx + (AW+1)'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end

            if (w_dec && w_is_zero) begin
                r_idx    <= '0;
                overflow <= 1'b0;
            end

            if (w_fd) begin
                frame_done <= 1'b1;
                npix       <= r_idx;
            end
        end
    end

`ifdef SK9822_RX_STATUS_EN
    logic [15:0] r_frame_count;
    logic [7:0]  r_error_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_count <= '0;
            r_error_count <= '0;
        end else begin
            if (w_fd) r_frame_count <= r_frame_count + 16'd1;
            if (w_err && (r_error_count != 8'hFF)) r_error_count <= r_error_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
    assign error_count = r_error_count;
`else
    assign frame_count = 16'd0;
    assign error_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sk9822_rx.sv
// ============================================================================
// Module   : tb_sk9822_rx
// Brief    : Directed self-checking bench for sk9822_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sk9822_rx;

    localparam int NLEDS   = 16;
    localparam int TIMEOUT = 1024;
    localparam int AW      = $clog2(NLEDS);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          led_ck = 1'b0;
    logic          led_data = 1'b0;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          frame_done;
    logic [AW:0]   npix;
    logic          overflow;
    logic [15:0]   frame_count;
    logic [7:0]    error_count;

    int checks   = 0;
    int failures = 0;

`ifdef SK9822_RX_STATUS_EN
    localparam int EXP_ERR1 = 1;
    localparam int EXP_FC2  = 2;
`else
    localparam int EXP_ERR1 = 0;
    localparam int EXP_FC2  = 0;
`endif

    sk9822_rx #(.NLEDS(NLEDS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .led_ck(led_ck), .led_data(led_data),
        .we(we), .waddr(waddr), .wdata(wdata), .frame_done(frame_done),
        .npix(npix), .overflow(overflow), .frame_count(frame_count),
        .error_count(error_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge, away from the DUT's active edge.
    logic [3:0]  la  [0:255];
    logic [31:0] ld  [0:255];
    logic [4:0]  lnp [0:255];
    int          fdc [0:255];
    int nwe = 0, nfd = 0, nboth = 0, rise_cyc = 0;

    always @(negedge clk) begin
        if (we && nwe < 256) begin
            la[nwe] = waddr;
            ld[nwe] = wdata;
            nwe++;
        end
        if (frame_done && nfd < 256) begin
            lnp[nfd] = npix;
            fdc[nfd] = cyc;
            nfd++;
        end
        if (we && frame_done) nboth++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; led_ck = 1'b0; led_data = 1'b0;
        settle(4);
        reset = 1'b0;
        settle(2);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        led_data = b;
        settle(4);
        led_ck   = 1'b1;
        rise_cyc = cyc;
        settle(4);
        led_ck   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 8;
        if (we !== 1'b0)          begin failures++; $display("FAIL reset_we got=%b exp=0", we); end
        if (waddr !== '0)         begin failures++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
        if (wdata !== 32'h0)      begin failures++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
        if (frame_done !== 1'b0)  begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        if (npix !== '0)          begin failures++; $display("FAIL reset_npix got=%0d exp=0", npix); end
        if (overflow !== 1'b0)    begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        if (frame_count !== 16'h0) begin failures++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
        if (error_count !== 8'h0) begin failures++; $display("FAIL reset_error_count got=%0d exp=0", error_count); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [0:2];
        int bw, bf;
        exp_d[0] = 32'h0100_00FF; exp_d[1] = 32'h0500_FF00; exp_d[2] = 32'h1FFF_0000;
        do_reset();
        bw = nwe; bf = nfd;
        send_zeros(32);
        send_word(32'hE100_00FF);
        send_word(32'hE500_FF00);
        send_word(32'hFFFF_0000);
        send_word(32'hFFFF_FFFF);
        settle(10);
        checks++;
        if (nwe - bw !== 3) begin failures++; $display("FAIL basic_nwrites got=%0d exp=3", nwe - bw); end
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (la[bw+i] !== 4'(i)) begin failures++; $display("FAIL basic_waddr[%0d] got=%0d exp=%0d", i, la[bw+i], i); end
            if (ld[bw+i] !== exp_d[i]) begin failures++; $display("FAIL basic_wdata[%0d] got=%h exp=%h", i, ld[bw+i], exp_d[i]); end
        end
        checks += 4;
        if (nfd - bf !== 1)    begin failures++; $display("FAIL basic_frame_done got=%0d exp=1", nfd - bf); end
        if (npix !== 5'd3)     begin failures++; $display("FAIL basic_npix got=%0d exp=3", npix); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
        if (nboth !== 0)       begin failures++; $display("FAIL basic_we_with_done got=%0d exp=0", nboth); end
    endtask

    task automatic test_overflow();
        int bw, bf;
        do_reset();
        bw = nwe; bf = nfd;
        send_zeros(32);
        for (int i = 0; i < 18; i++) send_word(32'hE000_0000 + 32'(i));
        send_word(32'hFFFF_FFFF);
        settle(10);
        checks++;
        if (nwe - bw !== 16) begin failures++; $display("FAIL ovf_nwrites got=%0d exp=16", nwe - bw); end
        for (int i = 0; i < 16; i++) begin
            checks += 2;
            if (la[bw+i] !== 4'(i)) begin failures++; $display("FAIL ovf_waddr[%0d] got=%0d exp=%0d", i, la[bw+i], i); end
            if (ld[bw+i] !== 32'(i)) begin failures++; $display("FAIL ovf_wdata[%0d] got=%h exp=%h", i, ld[bw+i], i); end
        end
        checks += 3;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        if (npix !== 5'd16)    begin failures++; $display("FAIL ovf_npix got=%0d exp=16", npix); end
        if (nfd - bf !== 1)    begin failures++; $display("FAIL ovf_frame_done got=%0d exp=1", nfd - bf); end
        send_zeros(32);
        settle(10);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        settle(TIMEOUT + 50);
    endtask

    task automatic test_error();
        int bw, bf;
        do_reset();
        bw = nwe; bf = nfd;
        send_zeros(32);
        send_word(32'h4000_0000);
        settle(10);
        checks += 3;
        if (nwe - bw !== 0) begin failures++; $display("FAIL err_nwrites got=%0d exp=0", nwe - bw); end
        if (nfd - bf !== 0) begin failures++; $display("FAIL err_frame_done got=%0d exp=0", nfd - bf); end
        if (error_count !== 8'(EXP_ERR1)) begin failures++; $display("FAIL err_count got=%0d exp=%0d", error_count, EXP_ERR1); end
        // In HUNT a pixel word without a start frame must be ignored.
        send_word(32'hE100_00FF);
        settle(10);
        checks++;
        if (nwe - bw !== 0) begin failures++; $display("FAIL err_hunt_write got=%0d exp=0", nwe - bw); end
        send_zeros(32);
        send_word(32'hEACD_EF12);
        send_word(32'hFFFF_FFFF);
        settle(10);
        checks += 4;
        if (nwe - bw !== 1) begin failures++; $display("FAIL err_recover_nwrites got=%0d exp=1", nwe - bw); end
        if (la[bw] !== 4'd0) begin failures++; $display("FAIL err_recover_waddr got=%0d exp=0", la[bw]); end
        if (ld[bw] !== 32'h0ACD_EF12) begin failures++; $display("FAIL err_recover_wdata got=%h exp=0acdef12", ld[bw]); end
        if (nfd - bf !== 1) begin failures++; $display("FAIL err_recover_done got=%0d exp=1", nfd - bf); end
    endtask

    task automatic test_timeout();
        int bw, bf, lat;
        do_reset();
        bw = nwe; bf = nfd;
        send_zeros(32);
        send_word(32'hE100_00FF);
        send_word(32'hE200_FF00);
        settle(1100);
        lat = fdc[bf] - rise_cyc;
        checks += 4;
        if (nfd - bf !== 1) begin failures++; $display("FAIL to_frame_done got=%0d exp=1", nfd - bf); end
        if (npix !== 5'd2)  begin failures++; $display("FAIL to_npix got=%0d exp=2", npix); end
        if (nwe - bw !== 2) begin failures++; $display("FAIL to_nwrites got=%0d exp=2", nwe - bw); end
        if (lat < TIMEOUT + 1 || lat > TIMEOUT + 5)
            begin failures++; $display("FAIL to_latency got=%0d exp=%0d..%0d", lat, TIMEOUT + 1, TIMEOUT + 5); end
    endtask

    task automatic test_zero_frame();
        int bw, bf;
        do_reset();
        bw = nwe; bf = nfd;
        send_zeros(32);
        send_word(32'hE100_00FF);
        send_zeros(32);
        send_word(32'hFFFF_0000);
        send_word(32'hFFFF_FFFF);
        settle(10);
        checks += 9;
        if (nfd - bf !== 2)     begin failures++; $display("FAIL zf_frame_done got=%0d exp=2", nfd - bf); end
        if (lnp[bf] !== 5'd1)   begin failures++; $display("FAIL zf_npix0 got=%0d exp=1", lnp[bf]); end
        if (lnp[bf+1] !== 5'd1) begin failures++; $display("FAIL zf_npix1 got=%0d exp=1", lnp[bf+1]); end
        if (nwe - bw !== 2)     begin failures++; $display("FAIL zf_nwrites got=%0d exp=2", nwe - bw); end
        if (la[bw] !== 4'd0)    begin failures++; $display("FAIL zf_waddr0 got=%0d exp=0", la[bw]); end
        if (la[bw+1] !== 4'd0)  begin failures++; $display("FAIL zf_waddr1 got=%0d exp=0", la[bw+1]); end
        if (ld[bw] !== 32'h0100_00FF)   begin failures++; $display("FAIL zf_wdata0 got=%h exp=010000ff", ld[bw]); end
        if (ld[bw+1] !== 32'h1FFF_0000) begin failures++; $display("FAIL zf_wdata1 got=%h exp=1fff0000", ld[bw+1]); end
        if (frame_count !== 16'(EXP_FC2)) begin failures++; $display("FAIL zf_frame_count got=%0d exp=%0d", frame_count, EXP_FC2); end
        checks++;
        if (nboth !== 0) begin failures++; $display("FAIL zf_we_with_done got=%0d exp=0", nboth); end
    endtask

    task automatic test_reset_mid();
        int bw, bf;
        logic [31:0] w;
        do_reset();
        w = 32'hE500_FF00;
        send_zeros(32);
        send_word(32'hE100_00FF);
        for (int i = 31; i >= 12; i--) send_bit(w[i]);
        @(negedge clk);
        reset = 1'b1;
        settle(3);
        reset = 1'b0;
        settle(1);
        checks += 5;
        if (we !== 1'b0)       begin failures++; $display("FAIL rm_we got=%b exp=0", we); end
        if (waddr !== '0)      begin failures++; $display("FAIL rm_waddr got=%0d exp=0", waddr); end
        if (wdata !== 32'h0)   begin failures++; $display("FAIL rm_wdata got=%h exp=0", wdata); end
        if (npix !== '0)       begin failures++; $display("FAIL rm_npix got=%0d exp=0", npix); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL rm_overflow got=%b exp=0", overflow); end
        bw = nwe; bf = nfd;
        for (int i = 11; i >= 0; i--) send_bit(w[i]);
        send_word(32'hE300_0011);
        send_word(32'hFFFF_FFFF);
        settle(10);
        checks += 2;
        if (nwe - bw !== 0) begin failures++; $display("FAIL rm_resume_writes got=%0d exp=0", nwe - bw); end
        if (nfd - bf !== 0) begin failures++; $display("FAIL rm_resume_done got=%0d exp=0", nfd - bf); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_error();
        test_timeout();
        test_zero_frame();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
